// File: rtl/packet_pkg.sv
// Shared types and helpers for the switch egress packet path.
package packet_pkg;

  localparam int unsigned NUM_PORTS = 4;
  localparam int unsigned SRC_W     = 4;
  localparam int unsigned DATA_W    = 8;

  typedef struct packed {
    logic [1:0] src_idx;
    logic [7:0] data;
  } rx_entry_t;

  function automatic logic is_onehot(input logic [SRC_W-1:0] oh);
    return $countones(oh) == 1;
  endfunction

  function automatic logic [1:0] onehot_to_idx(input logic [SRC_W-1:0] oh);
    logic [1:0] idx;
    idx = '0;
    for (int i = 0; i < SRC_W; i++) begin
      if (oh[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; extra pointer bit separates full from empty. A push while
// full is accepted when a pop happens on the same edge.
module sync_fifo #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic             do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/port_egress_rx.sv
// Egress-port receiver: routing checks, FIFO buffering toward a consumer and
// saturating per-source / drop / error statistics.
module port_egress_rx
  import packet_pkg::*;
#(
  parameter int unsigned PORT_ID = 0,
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pkt_valid_i,
  input  logic [SRC_W-1:0]     pkt_source_i,
  input  logic [SRC_W-1:0]     pkt_target_i,
  input  logic [DATA_W-1:0]    pkt_data_i,
  output logic                 rd_valid_o,
  input  logic                 rd_ready_i,
  output logic [1:0]           rd_src_idx_o,
  output logic [DATA_W-1:0]    rd_data_o,
  input  logic                 clear_stats_i,
  output logic [4*CNT_W-1:0]   src_cnt_o,
  output logic [CNT_W-1:0]     drop_cnt_o,
  output logic [CNT_W-1:0]     err_cnt_o,
  output logic                 overflow_o,
  output logic                 misroute_o
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  rx_entry_t push_entry, head;
  logic      fifo_full, fifo_empty;
  logic      src_ok, tgt_ok, good, pop, push, drop, err, misroute_evt;

  logic [CNT_W-1:0] src_cnt_q [NUM_PORTS];
  logic [CNT_W-1:0] drop_cnt_q, err_cnt_q;
  logic             overflow_q, misroute_q;

  assign src_ok       = is_onehot(pkt_source_i);
  assign tgt_ok       = pkt_target_i[PORT_ID];
  assign good         = pkt_valid_i & src_ok & tgt_ok;
  assign pop          = rd_valid_o & rd_ready_i;
  assign push         = good & (~fifo_full | pop);
  assign drop         = good & fifo_full & ~pop;
  assign err          = pkt_valid_i & ~(src_ok & tgt_ok);
  assign misroute_evt = pkt_valid_i & src_ok & ~tgt_ok;

  assign push_entry.src_idx = onehot_to_idx(pkt_source_i);
  assign push_entry.data    = pkt_data_i;

  sync_fifo #(
    .WIDTH ($bits(rx_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (push_entry),
    .dout_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Head fields forced to zero while empty so stale RAM never leaks out.
  assign rd_valid_o   = ~fifo_empty;
  assign rd_src_idx_o = rd_valid_o ? head.src_idx : '0;
  assign rd_data_o    = rd_valid_o ? head.data : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_PORTS; i++) src_cnt_q[i] <= '0;
      drop_cnt_q <= '0;
      err_cnt_q  <= '0;
      overflow_q <= 1'b0;
      misroute_q <= 1'b0;
    end else if (clear_stats_i) begin
      for (int i = 0; i < NUM_PORTS; i++) src_cnt_q[i] <= '0;
      drop_cnt_q <= '0;
      err_cnt_q  <= '0;
      overflow_q <= 1'b0;
      misroute_q <= 1'b0;
    end else begin
      if (push) src_cnt_q[push_entry.src_idx] <= sat_inc(src_cnt_q[push_entry.src_idx]);
      if (drop) begin
        drop_cnt_q <= sat_inc(drop_cnt_q);
        overflow_q <= 1'b1;
      end
      if (err)          err_cnt_q  <= sat_inc(err_cnt_q);
      if (misroute_evt) misroute_q <= 1'b1;
    end
  end

  always_comb begin
    src_cnt_o = '0;
    for (int i = 0; i < NUM_PORTS; i++) src_cnt_o[i*CNT_W +: CNT_W] = src_cnt_q[i];
  end

  assign drop_cnt_o = drop_cnt_q;
  assign err_cnt_o  = err_cnt_q;
  assign overflow_o = overflow_q;
  assign misroute_o = misroute_q;

endmodule

// File: doc/port_egress_rx.md
Name: port_egress_rx

Overview:
- Receiver for one switch_4port egress port. It is the sink end of port_if's output side.
- Each accepted packet is checked for routing consistency: the target must include this port and the source must be exactly one-hot.
- Good packets are buffered in a FIFO and handed to a consumer over a valid/ready interface.
- Per-source packet counts plus drop and error statistics are kept for scoreboarding and system-level debug.

Parameters:
- PORT_ID, 0, index (0-3) of the switch port this receiver is attached to.
- DEPTH, 8, FIFO entries; power of two, 2 or more.
- CNT_W, 16, width of each statistics counter.

Ports:
- clk  in  1  single clock domain; all logic on its rising edge
- rst  in  1  asynchronous, active-high reset
- pkt_valid_i  in  1  egress valid (port valid_out); one packet per cycle, no backpressure toward the switch
- pkt_source_i  in  4  one-hot source (source_out)
- pkt_target_i  in  4  target mask (target_out)
- pkt_data_i  in  8  payload (data_out)
- rd_valid_o  out  1  head-of-FIFO packet available
- rd_ready_i  in  1  consumer accepts head when rd_valid_o is high
- rd_src_idx_o  out  2  binary index of head packet's source
- rd_data_o  out  8  head packet payload
- clear_stats_i  in  1  synchronous clear of all counters and sticky flags
- src_cnt_o  out  4*CNT_W  packets accepted per source index; slice i = source i
- drop_cnt_o  out  CNT_W  valid packets dropped because the FIFO was full
- err_cnt_o  out  CNT_W  packets rejected by checks
- overflow_o  out  1  sticky; set on first overflow drop
- misroute_o  out  1  sticky; set on a target-mask error

Behaviour:
- Reset (rst high, asynchronous):
  - FIFO emptied; rd_valid_o=0; rd_src_idx_o=0; rd_data_o=0.
  - All counters 0; overflow_o=0; misroute_o=0.
  - Reset mid-operation discards all buffered packets.
- Sampling: a packet is sampled on any rising clk edge where pkt_valid_i=1. Fields are ignored when pkt_valid_i=0.
- Check order, evaluated in the sampling cycle:
  - (a) Source not exactly one-hot (0000, or 2 or more bits set): reject, err_cnt+1. No sticky flag.
  - (b) Otherwise, pkt_target_i[PORT_ID]=0: reject, err_cnt+1, misroute_o set.
  - (c) Otherwise the packet is good.
- Good packet, FIFO not full: pushed as {onehot-to-index(source), data}; src_cnt[idx]+1.
- Good packet, FIFO full and no pop this cycle: dropped, drop_cnt+1, overflow_o set. src_cnt is not incremented.
- Full FIFO with a simultaneous pop (rd_valid_o & rd_ready_i) in the same cycle: push accepted, no drop.
- Latency: a packet sampled at edge N into an empty FIFO gives rd_valid_o=1 with its fields after edge N (visible in cycle N+1). There is no combinational path from pkt_* to rd_*.
- Read handshake:
  - rd_src_idx_o and rd_data_o are valid and stable while rd_valid_o=1 and the head has not been popped.
  - Pop happens on an edge where rd_valid_o & rd_ready_i.
  - rd_ready_i while empty has no effect.
- Ordering: strict FIFO. Pointers wrap modulo DEPTH; full and empty are distinguished by an extra pointer bit or an occupancy count.
- Counters:
  - Saturate at 2^CNT_W-1; never wrap.
  - clear_stats_i=1 zeroes all counters and sticky flags at the next edge. FIFO contents are unaffected.
  - If clear coincides with an increment event, clear wins and the counter is 0 afterwards.
- Outputs are registered or derived directly from registered state (FIFO head, counters).

Decomposition:
- packet_pkg additions:
  - NUM_PORTS=4, SRC_W=4, DATA_W=8.
  - rx_entry_t struct {logic [1:0] src_idx; logic [7:0] data}.
  - Functions onehot_to_idx() and is_onehot().
- Sub-module sync_fifo:
  - Parameters WIDTH, DEPTH.
  - Ports push, pop, din, dout, full, empty.
  - Same clk/rst.
  - Instantiated with WIDTH = $bits(rx_entry_t).
- Check and statistics logic stays in port_egress_rx.

Test Plan:
1. PORT_ID=2, rd_ready_i=1: pkt src=0001, tgt=1100, data=A0 -> rd_valid_o=1 one cycle later with idx=0, data=A0; src_cnt[0]=1; err_cnt=0.
2. rd_ready_i=0; push 9 good packets data 01..09, DEPTH=8 -> 8 buffered; drop_cnt=1; overflow_o=1. Then raise ready -> reads 01..08 in order, then rd_valid_o=0.
3. FIFO full, same cycle push 55 and pop -> no drop; 55 read last. drop_cnt unchanged.
4. PORT_ID=2: src=0011 tgt=0100 -> err_cnt=1, misroute_o=0. src=0100 tgt=0011 -> err_cnt=2, misroute_o=1. Neither packet appears on rd_*.
5. Back-to-back packets every cycle (src 0001, 0010, 1000, data CC, DD, EE), ready=1 -> output CC, DD, EE on consecutive cycles; src_cnt = {1,1,0,1}.
6. Assert rst with 3 entries buffered -> rd_valid_o=0 immediately (asynchronous); counters 0. After release, a new packet arrives with 1-cycle latency. clear_stats_i concurrent with a push -> src_cnt=0 afterwards, packet still readable.
